// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks: FSM state encoding, parity
// mode constants and the baud counter width calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // A divider of 2 still needs one counter bit, so the width never drops below 1.
    function automatic int baud_cnt_width(input int clks_per_bit);
        return (clks_per_bit > 2) ? $clog2(clks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-period divider: counts 0..P_CLKS_PER_BIT-1 and flags the last cycle of
// each bit period. Held at 0 while cleared so every frame starts on a fresh period.
module baud_tick
    import uart_pkg::*;
#(
    parameter int P_CLKS_PER_BIT = 434,
    parameter int P_CNT_W        = baud_cnt_width(P_CLKS_PER_BIT)
) (
    input  logic i_clk,
    input  logic i_nreset,
    input  logic i_clear,
    output logic o_tick
);

    localparam logic [P_CNT_W-1:0] LP_LAST = P_CNT_W'(P_CLKS_PER_BIT - 1);

    logic [P_CNT_W-1:0] r_cnt;

    // Bit-period counter with synchronous reset, clear and wrap at the bit boundary.
    always_ff @(posedge i_clk) begin
        if (!i_nreset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == LP_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + P_CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == LP_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts one word per valid/ready handshake and shifts it
// out as start bit, LSB-first data, optional parity and stop bit(s).
module uart_tx
    import uart_pkg::*;
#(
    parameter int P_DATA_WIDTH   = 8,
    parameter int P_CLKS_PER_BIT = 434,
    parameter int P_STOP_BITS    = 1,
    parameter int P_PARITY       = PARITY_NONE
) (
    input  logic                    I_CLK,
    input  logic                    I_NRESET,
    input  logic                    I_VALID,
    input  logic [P_DATA_WIDTH-1:0] I_DATA,
    output logic                    O_READY,
    output logic                    O_TX,
    output logic                    O_BUSY
);

    localparam int         LP_CNT_W      = baud_cnt_width(P_CLKS_PER_BIT);
    localparam logic [3:0] LP_LAST_DATA  = 4'(P_DATA_WIDTH - 1);
    localparam logic [3:0] LP_LAST_STOP  = 4'(P_STOP_BITS - 1);
    localparam bit         LP_HAS_PARITY = (P_PARITY != PARITY_NONE);

    if (P_CLKS_PER_BIT < 2) begin : g_bad_clks
        $error("uart_tx: P_CLKS_PER_BIT must be at least 2");
    end
    if ((P_STOP_BITS < 1) || (P_STOP_BITS > 2)) begin : g_bad_stop
        $error("uart_tx: P_STOP_BITS must be 1 or 2");
    end
    if ((P_PARITY < 0) || (P_PARITY > 2)) begin : g_bad_parity
        $error("uart_tx: P_PARITY must be 0, 1 or 2");
    end
    if ((P_DATA_WIDTH < 5) || (P_DATA_WIDTH > 9)) begin : g_bad_width
        $error("uart_tx: P_DATA_WIDTH must be in 5..9");
    end

    function automatic logic frame_parity(input logic [P_DATA_WIDTH-1:0] d);
        return (P_PARITY == PARITY_ODD) ? ~(^d) : (^d);
    endfunction

    uart_state_e             r_state;
    logic [P_DATA_WIDTH-1:0] r_shift;
    logic [3:0]              r_bit_cnt;
    logic                    r_parity;
    logic                    r_tx;
    logic                    r_ready;
    logic                    r_busy;
    logic                    w_tick;
    logic                    w_clear;

    assign w_clear = (r_state == IDLE);

    baud_tick #(
        .P_CLKS_PER_BIT(P_CLKS_PER_BIT),
        .P_CNT_W       (LP_CNT_W)
    ) u_baud_tick (
        .i_clk   (I_CLK),
        .i_nreset(I_NRESET),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

    // Frame sequencer; O_TX/O_READY/O_BUSY are loaded with the value of the state being entered.
    always_ff @(posedge I_CLK) begin
        if (!I_NRESET) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= 4'd0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (I_VALID && r_ready) begin
                        r_shift   <= I_DATA;
                        r_parity  <= frame_parity(I_DATA);
                        r_bit_cnt <= 4'd0;
                        r_state   <= START;
                        r_tx      <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= r_shift >> 1;
                        if (r_bit_cnt == LP_LAST_DATA) begin
                            r_bit_cnt <= 4'd0;
                            if (LP_HAS_PARITY) begin
                                r_state <= PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LP_LAST_STOP) begin
                            r_bit_cnt <= 4'd0;
                            r_state   <= IDLE;
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_bit_cnt <= 4'd0;
                    r_tx      <= 1'b1;
                    r_ready   <= 1'b1;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign O_TX    = r_tx;
    assign O_READY = r_ready;
    assign O_BUSY  = r_busy;

endmodule
